// File: rtl/lp_arith_pkg.sv
// ----------------------------------------------------------------------------
// lp_arith_pkg
//   Shared types for the sequential add/sub/mul unit.
//   - op_t    : request opcode encoding as seen on the op port.
//   - state_t : control FSM states of lp_arith_seq_unit.
//   - res_w() : result width helper, RES_W = 2*WIDTH.
// ----------------------------------------------------------------------------
package lp_arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_NOP = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Result width for a given operand width. Constant function so it can size
  // localparams in the modules that import this package.
  function automatic int res_w(input int width);
    return 2 * width;
  endfunction

endpackage : lp_arith_pkg

// File: rtl/lp_shift_add_mul.sv
// ----------------------------------------------------------------------------
// lp_shift_add_mul
//   Iterative shift-add multiplier datapath (no array multiplier).
//   Holds the multiplicand, multiplier and accumulator registers; the owning
//   FSM decides when to load and when to step.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   load_i      in   load a_i/b_i and clear the accumulator
//   step_i      in   perform one shift-add iteration
//   a_i         in   multiplicand (unsigned, WIDTH bits)
//   b_i         in   multiplier   (unsigned, WIDTH bits)
//   done_next_o out  the iteration in progress this cycle is the last one
//   product_o   out  accumulator contents (final product once done)
// ----------------------------------------------------------------------------
module lp_shift_add_mul
  import lp_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic [WIDTH-1:0]        a_i,
  input  logic [WIDTH-1:0]        b_i,
  output logic                    done_next_o,
  output logic [res_w(WIDTH)-1:0] product_o
);

  localparam int RES_W = res_w(WIDTH);

  logic [RES_W-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [RES_W-1:0] acc_q, acc_d;

  // NOTE: every variable assigned in always_comb gets a default first
  // (hold value here), so no path through the block can infer a latch.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its _d value from before the edge, independent of
  // statement order or of other always_ff blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // The multiplier becomes zero after this shift when no bit above bit 0 is
  // set, so this step is the final one and early termination kicks in.
  assign done_next_o = (mplier_q[WIDTH-1:1] == '0);
  assign product_o   = acc_q;

endmodule : lp_shift_add_mul

// File: rtl/lp_arith_seq_unit.sv
// ----------------------------------------------------------------------------
// lp_arith_seq_unit
//   Handshaked add / sub / multiply unit. ADD, SUB and NOP complete in one
//   cycle; MUL runs on an iterative shift-add multiplier that stops as soon as
//   the remaining multiplier bits are zero.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   request valid
//   in_ready   out  unit accepts a request this cycle
//   a, b       in   unsigned operands, WIDTH bits
//   op         in   00 ADD, 01 SUB, 10 MUL, 11 NOP
//   out_valid  out  result valid
//   out_ready  in   consumer takes the result
//   result     out  2*WIDTH-bit result
//   busy       out  high while iterating the multiplier
// ----------------------------------------------------------------------------
module lp_arith_seq_unit
  import lp_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int RES_W = res_w(WIDTH);

  state_t           state_q;
  op_t              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             out_valid_q;
  logic             busy_q;

  op_t              req_op;
  logic             accept;
  logic             mul_trivial;
  logic             mul_load;
  logic             mul_step;
  logic             mul_done_next;
  logic [RES_W-1:0] mul_product;

  assign req_op      = op_t'(op);
  // A finished result can be replaced in the same cycle it is consumed, which
  // is what gives one ADD/SUB/NOP per cycle with out_ready tied high.
  assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept      = in_valid && in_ready;
  assign mul_trivial = (a == '0) || (b == '0);
  assign mul_load    = accept && (req_op == OP_MUL);
  assign mul_step    = (state_q == MUL);

  lp_shift_add_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk         (clk),
    .rst         (rst),
    .load_i      (mul_load),
    .step_i      (mul_step),
    .a_i         (a),
    .b_i         (b),
    .done_next_o (mul_done_next),
    .product_o   (mul_product)
  );

  // Control FSM. Operand registers are only enabled on an accepted ADD, SUB
  // or MUL; a NOP records its opcode but leaves the operands untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            op_q <= req_op;
            if (req_op != OP_NOP) begin
              a_q <= a;
              b_q <= b;
            end
            if ((req_op == OP_MUL) && !mul_trivial) begin
              state_q     <= MUL;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              // ADD/SUB/NOP, and MUL by zero (product is the cleared acc).
              state_q     <= DONE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end else if ((state_q == DONE) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        MUL: begin
          if (mul_done_next) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Result is decoded from registered state only (op_q, a_q, b_q, acc), so it
  // is glitch-free and stays stable for as long as DONE is held. After reset
  // op_q = ADD with zero operands, which decodes to 0.
  always_comb begin
    result = '0;
    case (op_q)
      OP_ADD:  result = {{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q};
      OP_SUB:  result = {{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q};
      OP_MUL:  result = mul_product;
      default: result = '0;
    endcase
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule : lp_arith_seq_unit

// File: tb/tb_lp_arith_seq_unit.sv
// ----------------------------------------------------------------------------
// tb_lp_arith_seq_unit
//   Directed vectors with hand-computed results. Each accepted request pushes
//   its expected result and latency into a scoreboard; a negedge monitor pops
//   and compares whenever a result transfers (out_valid && out_ready).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lp_arith_seq_unit;
  import lp_arith_pkg::*;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] result;
  logic          busy;

  always #5 clk = ~clk;

  lp_arith_seq_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  typedef struct {
    logic [2*W-1:0] res;
    int             lat;    // cycles from accept edge to transfer
    longint         t_acc;  // time of the accept edge
    string          name;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_bad    = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every transferred result against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_output: got result 0x%0h, expected no transfer", result);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, 32'(result), 32'(e.res));
        check({e.name, "_latency"}, 32'(int'(($time - e.t_acc + 5) / 10)), 32'(e.lat));
      end
    end
  end

  // Issue one request; returns at accept edge + 1ns with inputs still driven.
  task automatic send(input string name, input logic [1:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [2*W-1:0] exp_res,
                      input int exp_lat, input bit expect_out, output int tries);
    logic rdy;
    exp_t e;
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    tries    = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      tries++;
    end while (!rdy && tries < 200);
    if (!rdy) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_accept: in_ready low for %0d cycles, expected acceptance", name, tries);
    end else if (expect_out) begin
      e.res   = exp_res;
      e.lat   = exp_lat;
      e.t_acc = longint'($time);
      e.name  = name;
      sb.push_back(e);
    end
    #1;
  endtask

  // Drop the request and scribble on the operands: they must only matter at accept.
  task automatic idle();
    in_valid = 1'b0;
    op       = 2'b10;
    a        = 8'hC3;
    b        = 8'h3C;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tries;
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD with carry into bit WIDTH; out_valid for exactly one cycle
    send("add_ff_01", OP_ADD, 8'hFF, 8'h01, 16'h0100, 1, 1'b1, tries);
    idle();
    @(negedge clk);
    check("add_valid_t1", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("add_valid_one_cycle", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // SUB wrapping negative, then ADD 0+0 back-to-back
    send("sub_3_5", OP_SUB, 8'd3, 8'd5, 16'hFFFE, 1, 1'b1, tries);
    check("sub_accept_first_try", 32'(tries), 32'd1);
    send("add_0_0_b2b", OP_ADD, 8'd0, 8'd0, 16'h0000, 1, 1'b1, tries);
    check("b2b_accept_first_try", 32'(tries), 32'd1);
    idle();
    drain();

    // MUL full-scale: k = 8
    busy_cnt = 0;
    send("mul_ff_ff", OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 9, 1'b1, tries);
    idle();
    drain();
    check("mul_ff_busy_cycles", 32'(busy_cnt), 32'd8);

    // MUL early termination: b = 2 -> k = 2
    busy_cnt = 0;
    send("mul_12_2", OP_MUL, 8'd12, 8'd2, 16'd24, 3, 1'b1, tries);
    idle();
    drain();
    check("mul_12_2_busy_cycles", 32'(busy_cnt), 32'd2);

    // MUL by zero skips the MUL state
    busy_cnt = 0;
    send("mul_7_0", OP_MUL, 8'd7, 8'd0, 16'd0, 1, 1'b1, tries);
    idle();
    drain();
    check("mul_7_0_busy_cycles", 32'(busy_cnt), 32'd0);

    // Backpressure: MUL 5*6 (k = 3) held 4 cycles, competing ADD held off
    out_ready = 1'b0;
    send("mul_5_6_bp", OP_MUL, 8'd5, 8'd6, 16'd30, 8, 1'b1, tries);
    in_valid = 1'b1;
    op       = OP_ADD;
    a        = 8'd1;
    b        = 8'd2;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    check("bp_valid_seen", 32'(out_valid), 32'd1);
    check("bp_valid_latency", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_hold_result",   32'(result),    32'd30);
      check("bp_hold_valid",    32'(out_valid), 32'd1);
      check("bp_in_ready_low",  32'(in_ready),  32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send("bp_next_add_1_2", OP_ADD, 8'd1, 8'd2, 16'd3, 1, 1'b1, tries);
    check("bp_next_accept_first_try", 32'(tries), 32'd1);
    idle();
    drain();

    // NOP after ADD: result 0, operand registers keep 9/4
    send("add_9_4", OP_ADD, 8'd9, 8'd4, 16'd13, 1, 1'b1, tries);
    send("nop", OP_NOP, 8'h77, 8'h55, 16'd0, 1, 1'b1, tries);
    idle();
    drain();
    check("nop_keeps_a_q", 32'(dut.a_q), 32'd9);
    check("nop_keeps_b_q", 32'(dut.b_q), 32'd4);

    // Reset at T+2 of MUL 200*200 aborts it; no result is produced
    send("mul_200_200_rst", OP_MUL, 8'd200, 8'd200, 16'd0, 0, 1'b0, tries);
    idle();
    @(posedge clk); #1;
    check("mul_rst_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mul_rst_out_valid", 32'(out_valid), 32'd0);
    check("mul_rst_result",    32'(result),    32'd0);
    check("mul_rst_busy",      32'(busy),      32'd0);
    check("mul_rst_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send("add_1_1_after_rst", OP_ADD, 8'd1, 8'd1, 16'd2, 1, 1'b1, tries);
    idle();
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_lp_arith_seq_unit

// File: doc/lp_arith_seq_unit.md
Name: lp_arith_seq_unit

Overview:
Parametrised, handshaked successor to the team's combinational add/sub/mul unit. It performs add, sub and multiply using an iterative shift-add multiplier, so no full array multiplier is instantiated. The multiplier terminates early once the remaining multiplier bits are zero. Operand registers are clock-enabled only when an operation is accepted, and op 2'b11 (NOP) leaves them untouched to save power. The block sits between a valid/ready request source and a valid/ready result consumer.

Parameters:
WIDTH, 8, operand width in bits; result width is 2*WIDTH. Legal range is WIDTH >= 2.

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  reset, asynchronous and active-high
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request this cycle
a  in  WIDTH  operand A, unsigned
b  in  WIDTH  operand B, unsigned
op  in  2  00=ADD, 01=SUB, 10=MUL, 11=NOP
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
result  out  2*WIDTH  operation result
busy  out  1  high while in state MUL

Behaviour:
- Accept: a request is accepted when in_valid && in_ready at a rising edge (cycle T).
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- States:
  - IDLE: waiting for a request.
  - MUL: iterating the multiplier.
  - DONE: result is presented until it is consumed.
- Reset (async, active-high):
  - state = IDLE, out_valid = 0, result = 0, busy = 0, in_ready = 1.
  - Operand and accumulator registers = 0.
  - Reset during MUL aborts the operation; no result is produced.
- ADD: result = zero-extended a + b, with the carry landing in bit WIDTH. Go to DONE at T+1.
- SUB: result = (zext(a) - zext(b)) mod 2^(2*WIDTH), i.e. a 2*WIDTH-bit two's complement value. Go to DONE at T+1.
- NOP: result = 0. Operand, multiplicand and multiplier registers are not written. Go to DONE at T+1.
- MUL, on accept:
  - Load mcand = zext(a), mplier = b, acc = 0.
  - If a==0 or b==0, go directly to DONE at T+1 with result 0. Otherwise go to MUL.
- MUL, each cycle in MUL:
  - If mplier[0], then acc += mcand.
  - mcand <<= 1; mplier >>= 1.
  - When the shifted mplier becomes 0, go to DONE with result = the final acc.
- MUL latency: out_valid asserts at T+1+k, where k = (index of the most significant set bit of b) + 1, with 1 <= k <= WIDTH.
- All arithmetic is unsigned and modulo 2^(2*WIDTH). MUL never overflows.
- DONE:
  - out_valid = 1.
  - result is held stable while out_ready = 0; in_valid is ignored unless in_ready is high.
  - On out_ready: if a new request is accepted in the same cycle, process it (back-to-back operation); otherwise return to IDLE.
- Throughput: one ADD/SUB/NOP per cycle when out_ready is tied high.
- op, a and b are sampled only at accept. Changes at any other time have no effect.

Decomposition:
- Package lp_arith_pkg:
  - op_t enum: OP_ADD, OP_SUB, OP_MUL, OP_NOP.
  - state_t enum: IDLE, MUL, DONE.
  - Localparam helper for RES_W = 2*WIDTH.
- Sub-module lp_shift_add_mul:
  - Holds the mcand, mplier and acc registers.
  - Inputs: load and step.
  - Outputs: done_next and product.
- The top level holds the FSM, the add/sub path and the handshake.

Test Plan:
- ADD a=8'hFF, b=8'h01, out_ready=1 -> result=16'h0100, out_valid at T+1 for exactly one cycle.
- SUB a=3, b=5 -> result=16'hFFFE at T+1. Then ADD 0+0 issued back-to-back at T+1 -> result=0 at T+2, with in_ready held high throughout.
- MUL a=8'hFF, b=8'hFF -> result=16'hFE01, out_valid at T+9, busy high T+1..T+8.
- MUL a=12, b=2 -> result=24 at T+3. MUL a=7, b=0 -> result=0 at T+1 with busy never asserted.
- Backpressure: MUL a=5, b=6 with out_ready=0 for 4 cycles after out_valid -> result=30 held stable, in_ready=0, and new requests are not accepted until out_ready=1.
- NOP after ADD 9+4 -> result=0, internal operand registers still hold 9/4. Assert rst at T+2 of MUL a=200, b=200 -> out_valid=0 and result=0 immediately; the next ADD 1+1 yields 2 at T+1.
